hs_resp_sync: RTL



---
 rtl/hs_resp_sync.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hs_resp_sync.sv
// Responder side of a 4-phase req/ack CDC handshake: synchronises req, captures data and presents it on valid/ready.
// Optional ACK-phase watchdog enabled by defining HS_RESP_TIMEOUT_EN.
module hs_resp_sync #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  xfer_cnt_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELIVER = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  // Only this chain samples the asynchronous request level.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Handshake FSM; ack_o/valid_o/data_o/xfer_cnt_o are all flop outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      ack_o      <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      xfer_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s) begin
            data_o  <= data_i;
            valid_o <= 1'b1;
            state   <= DELIVER;
          end
        end
        DELIVER: begin
          if (ready_i) begin
            valid_o    <= 1'b0;
            ack_o      <= 1'b1;
            xfer_cnt_o <= xfer_cnt_o + CNT_W'(1);
            state      <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack_o   <= 1'b0;
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef HS_RESP_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            ack_entry;
  logic            to_hit;

  assign ack_entry = (state == DELIVER) && ready_i;
  assign to_hit    = (state == ACK) && req_s && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Saturating ACK-phase counter; stopping at the limit prevents a second trigger.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt <= '0;
    end else if (ack_entry) begin
      to_cnt <= '0;
    end else if ((state == ACK) && req_s && (to_cnt != TO_W'(TIMEOUT_CYCLES))) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Sticky error; a set wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_o <= 1'b0;
    end else if (to_hit) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = err_clr_i ^ (TIMEOUT_CYCLES == 0);
  assign err_o     = 1'b0;
`endif

endmodule
